// File: rtl/dice_display_ctrl.sv
// Dice roll display controller: button synchroniser/debouncer, roll FSM and 7-segment drive.
// Optional build macro DICE_DECEL_EN adds a decelerating SETTLE phase between ROLL and SHOW.
module dice_display_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ANIM_PERIOD     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic [7:0] roll_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] result,
    output logic       roll_valid
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned AnimW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [6:0]  SegDash = 7'b1000000;

`ifdef DICE_DECEL_EN
    localparam int unsigned SetW = $clog2(16 * ANIM_PERIOD);
    typedef enum logic [1:0] {StIdle, StRoll, StSettle, StShow} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRoll, StShow} state_e;
`endif

    state_e state_q, state_d;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d, db_prev_q;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             press_ev, release_ev;

    logic [AnimW-1:0] anim_cnt_q, anim_cnt_d;
    logic [2:0]       disp_val_q, disp_val_d;
    logic             rel_seen_q, rel_seen_d;
    logic [2:0]       result_q, result_d;
    logic             roll_valid_q, roll_valid_d;
    logic             roll_ok, disp_ok;

`ifdef DICE_DECEL_EN
    logic [1:0]       step_q, step_d;
    logic [SetW-1:0]  set_cnt_q, set_cnt_d;
    logic [SetW-1:0]  step_last;
`endif

    // Debounce: count consecutive cycles of disagreement, flip once the run is long enough.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                db_d     = ~db_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press_ev   = db_q & ~db_prev_q;
    assign release_ev = ~db_q & db_prev_q;

    assign roll_ok = (roll_in >= 8'd1) && (roll_in <= 8'd6);
    assign disp_ok = (disp_val_q >= 3'd1) && (disp_val_q <= 3'd6);

`ifdef DICE_DECEL_EN
    // Step n (0..3) lasts (2 << n) * ANIM_PERIOD cycles.
    assign step_last = SetW'(((32'd2 << step_q) * ANIM_PERIOD) - 32'd1);
`endif

    always_comb begin
        state_d      = state_q;
        anim_cnt_d   = '0;
        disp_val_d   = disp_val_q;
        rel_seen_d   = rel_seen_q;
        result_d     = result_q;
        roll_valid_d = 1'b0;
`ifdef DICE_DECEL_EN
        step_d       = step_q;
        set_cnt_d    = set_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                rel_seen_d = 1'b0;
                if (press_ev) begin
                    state_d = StRoll;
                end
            end
            StRoll: begin
                anim_cnt_d = (anim_cnt_q == AnimW'(ANIM_PERIOD - 1)) ? '0 : anim_cnt_q + 1'b1;
                if (anim_cnt_q == '0 && roll_ok) begin
                    disp_val_d = roll_in[2:0];
                end
                if (release_ev) begin
                    rel_seen_d = 1'b1;
                end
                if ((rel_seen_q || release_ev) && disp_ok) begin
                    rel_seen_d = 1'b0;
`ifdef DICE_DECEL_EN
                    state_d   = StSettle;
                    step_d    = 2'd0;
                    set_cnt_d = '0;
`else
                    state_d      = StShow;
                    result_d     = disp_val_d;
                    roll_valid_d = 1'b1;
`endif
                end
            end
`ifdef DICE_DECEL_EN
            StSettle: begin
                if (set_cnt_q == step_last) begin
                    set_cnt_d = '0;
                    if (roll_ok) begin
                        disp_val_d = roll_in[2:0];
                    end
                    if (step_q == 2'd3) begin
                        state_d      = StShow;
                        result_d     = disp_val_d;
                        roll_valid_d = 1'b1;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
`endif
            StShow: begin
                if (press_ev) begin
                    state_d    = StRoll;
                    rel_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= StIdle;
            anim_cnt_q   <= '0;
            disp_val_q   <= 3'd0;
            rel_seen_q   <= 1'b0;
            result_q     <= 3'd0;
            roll_valid_q <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_prev_q    <= db_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            anim_cnt_q   <= anim_cnt_d;
            disp_val_q   <= disp_val_d;
            rel_seen_q   <= rel_seen_d;
            result_q     <= result_d;
            roll_valid_q <= roll_valid_d;
        end
    end

`ifdef DICE_DECEL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q    <= 2'd0;
            set_cnt_q <= '0;
        end else begin
            step_q    <= step_d;
            set_cnt_q <= set_cnt_d;
        end
    end
`endif

    function automatic logic [6:0] seg_code(input logic [2:0] v);
        case (v)
            3'd1:    seg_code = 7'b0000110;
            3'd2:    seg_code = 7'b1011011;
            3'd3:    seg_code = 7'b1001111;
            3'd4:    seg_code = 7'b1100110;
            3'd5:    seg_code = 7'b1101101;
            3'd6:    seg_code = 7'b1111101;
            default: seg_code = SegDash;
        endcase
    endfunction

    always_comb begin
        seg = SegDash;
        dp  = 1'b0;
        case (state_q)
            StIdle: seg = SegDash;
            StShow: begin
                seg = seg_code(disp_val_q);
                dp  = 1'b1;
            end
            default: seg = seg_code(disp_val_q);
        endcase
    end

    assign result     = result_q;
    assign roll_valid = roll_valid_q;

endmodule

// File: tb/tb_dice_display_ctrl.sv
// Randomised self-checking bench for dice_display_ctrl (DEBOUNCE_CYCLES = 4, ANIM_PERIOD = 2).
module tb_dice_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [7:0] roll_in;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] result;
    logic       roll_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    // Expected digit patterns; index 0 is the dash.
    logic [6:0] seg_tab [0:6] = '{7'b1000000, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101};

    always #5 clk = ~clk;

    dice_display_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .ANIM_PERIOD    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .roll_in   (roll_in),
        .seg       (seg),
        .dp        (dp),
        .result    (result),
        .roll_valid(roll_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (roll_valid === 1'b1) pulses++;
`ifdef DICE_DECEL_EN
        if (dut.release_ev === 1'b1) rel_cyc = cyc;
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (roll_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    function automatic bit seg_legal(input logic [6:0] s);
        seg_legal = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (s == seg_tab[i]) seg_legal = 1'b1;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        steps(3);
        check_eq("rst_seg", seg, seg_tab[0]);
        check_eq("rst_dp", dp, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_valid", roll_valid, 0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_seg", seg, seg_tab[0]);
        check_eq("post_rst_result", result, 0);
    endtask

    // One press/release with value v presented from release onward; expects a single result v.
    task automatic roll_and_check(input string tag, input int v, input int hold, input bit rnd);
        int p0;
        bit seen;
        int illegal;
        p0      = pulses;
        illegal = 0;
        btn     = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (rnd) roll_in = 8'($urandom);
            step();
            if (!seg_legal(seg)) illegal++;
        end
        check_eq({tag, "_seg_legal"}, illegal, 0);
        btn     = 1'b0;
        roll_in = 8'(v);
        wait_valid(200, seen);
        check_eq({tag, "_valid_seen"}, seen, 1);
`ifdef DICE_DECEL_EN
        check_eq({tag, "_settle_len"}, cyc - rel_cyc, 61);
`endif
        check_eq({tag, "_result"}, result, v);
        check_eq({tag, "_seg"}, seg, seg_tab[v]);
        check_eq({tag, "_dp"}, dp, 1);
        step();
        check_eq({tag, "_valid_1cyc"}, roll_valid, 0);
        steps(4);
        check_eq({tag, "_pulses"}, pulses - p0, 1);
    endtask

    initial begin
        bit seen;
        int p0;
        rst_n   = 1'b0;
        btn     = 1'b0;
        roll_in = 8'd0;
        do_reset();

        // Bouncing button never survives the debouncer.
        p0      = pulses;
        roll_in = 8'd3;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            steps(2);
        end
        btn = 1'b0;
        steps(20);
        check_eq("bounce_seg", seg, seg_tab[0]);
        check_eq("bounce_dp", dp, 0);
        check_eq("bounce_pulses", pulses - p0, 0);

        roll_and_check("basic", 3, 20, 1'b0);

        // Re-roll from SHOW keeps the old result until the next SHOW entry.
        btn = 1'b1;
        steps(12);
        check_eq("reroll_dp", dp, 0);
        check_eq("reroll_result", result, 3);
        check_eq("reroll_seg", seg, seg_tab[3]);
        p0 = pulses;
        do_reset();
        steps(10);
        check_eq("abort_seg", seg, seg_tab[0]);
        check_eq("abort_pulses", pulses - p0, 0);

        // Invalid roll values never load; FSM waits in ROLL.
        p0      = pulses;
        roll_in = 8'd0;
        btn     = 1'b1;
        steps(20);
        roll_in = 8'd7;
        btn     = 1'b0;
        steps(30);
        check_eq("inval_dp", dp, 0);
        check_eq("inval_seg", seg, seg_tab[0]);
        check_eq("inval_result", result, 0);
        check_eq("inval_pulses", pulses - p0, 0);
        roll_in = 8'd5;
        wait_valid(200, seen);
        check_eq("inval_valid_seen", seen, 1);
        check_eq("inval_result5", result, 5);
        check_eq("inval_seg5", seg, seg_tab[5]);
        step();

        for (int k = 0; k < 8; k++) begin
            roll_and_check($sformatf("rnd%0d", k), int'($urandom_range(1, 6)),
                           int'($urandom_range(12, 30)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dice_display_ctrl.md
DICE_DISPLAY_CTRL -- requirements
Module: dice_display_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter ANIM_PERIOD, default 8: cycles between roll samples while rolling; must be >= 1.
REQ-003 clk  input  1  clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 btn  input  1  raw roll button, asynchronous, active-high.
REQ-006 roll_in  input  8  roll value from the upstream LFSR stage; only values 1..6 are valid.
REQ-007 seg  output  7  seven-segment drive, active-high, seg[6:0] = {g,f,e,d,c,b,a}.
REQ-008 dp  output  1  decimal point; high while a final result is shown.
REQ-009 result  output  3  latched final roll, 1..6; 0 when no result exists.
REQ-010 roll_valid  output  1  single-cycle pulse when result updates.

Function
REQ-011 btn SHALL pass through a 2-flop synchroniser before any other use.
REQ-012 Debounce: the counter SHALL increment while the synchronised level differs from the debounced level and clear when they agree.
REQ-013 Debounce: when the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL flip and the counter SHALL clear.
REQ-014 press = debounced 0->1 edge; release = debounced 1->0 edge; each is a single-cycle internal event.
REQ-015 FSM states SHALL be IDLE, ROLL, SETTLE and SHOW.
REQ-016 IDLE: seg = 1000000 (dash), dp = 0; press -> ROLL.
REQ-017 ROLL: anim counter SHALL start at 0 on entry; roll_in SHALL be sampled on the entry cycle and every ANIM_PERIOD cycles after.
REQ-018 Sampling SHALL load disp_val only when roll_in is 1..6; otherwise disp_val SHALL hold.
REQ-019 ROLL: seg SHALL show disp_val, or the dash while disp_val = 0.
REQ-020 ROLL exit SHALL require release seen (sticky flag) AND disp_val in 1..6; until both hold, the FSM stays in ROLL and keeps sampling.
REQ-021 ROLL exit target SHALL be SETTLE when DICE_DECEL_EN is defined, otherwise SHOW.
REQ-022 SHOW entry: result <= disp_val and roll_valid = 1 for exactly that cycle.
REQ-023 SHOW: seg = disp_val, dp = 1; press -> ROLL, with result held until the next SHOW entry.
REQ-024 Segment codes: 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101.
REQ-025 Presses and releases in SETTLE SHALL be ignored; a release already consumed in ROLL SHALL NOT re-trigger.
REQ-026 roll_in changing every cycle SHALL NOT affect seg between sample points.

Reset
REQ-027 While rst_n = 0, and in the first cycle after release: FSM = IDLE, seg = 1000000, dp = 0, result = 0, roll_valid = 0, disp_val = 0.
REQ-028 While rst_n = 0, the synchroniser flops, debounced level and all counters SHALL clear to 0.
REQ-029 Reset asserted mid-ROLL or mid-SETTLE SHALL abort without a roll_valid pulse.

Configuration
REQ-030 Macro DICE_DECEL_EN defined: SETTLE runs 4 steps of length 2, 4, 8 and 16 x ANIM_PERIOD.
REQ-031 DICE_DECEL_EN defined: roll_in SHALL be sampled at the end of each step (per REQ-018), with seg tracking disp_val; after step 4 -> SHOW.
REQ-032 Macro DICE_DECEL_EN undefined: SETTLE and its counter SHALL be absent and ROLL goes directly to SHOW.

Verification (bench: DEBOUNCE_CYCLES = 4, ANIM_PERIOD = 2)
REQ-033 Reset: hold rst_n low 3 cycles -> seg = 1000000, dp = 0, result = 0, roll_valid = 0.
REQ-034 Bounce: btn toggles every 2 cycles for 20 cycles, then returns low -> FSM stays IDLE and no press is detected.
REQ-035 Basic roll (macro undefined): btn high 20 cycles with roll_in = 3 then low -> SHOW reached, result = 3, seg = 1001111, dp = 1, exactly one roll_valid pulse.
REQ-036 Invalid input: roll_in = 0 then 7 throughout a press and release -> FSM stays in ROLL; roll_in = 5 then applied -> SHOW with result = 5 after the next sample.
REQ-037 Decel (macro defined): roll_in = 2 held from release -> SHOW exactly 60 cycles after ROLL exit, result = 2.
REQ-038 Re-roll and reset: press in SHOW -> ROLL with result still 3 and dp = 0; rst_n low mid-ROLL -> IDLE, result = 0, no roll_valid pulse.
